// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rst_sequencer
//  Description : Supervises an MMCM and sequences its reset, lock debounce and
//                staggered per-domain reset release, with event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_sequencer #(
   parameter int N_CH                = 4,
   parameter int SYNC_STAGES         = 2,
   parameter int MMCM_RST_CYCLES     = 8,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int STAGGER_CYCLES      = 16,
   parameter int CNT_W               = 8
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             locked,
   input  logic             force_rst,
   input  logic             clr_cnt,
   output logic             mmcm_rst,
   output logic [N_CH-1:0]  ch_rst_n,
   output logic             all_ready,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam logic [2:0] S_MRST   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_STABLE = 3'd2;
   localparam logic [2:0] S_REL    = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;

   localparam int c_REL_LAST = (N_CH - 1) * STAGGER_CYCLES;
   localparam int c_TMAX_A   = (MMCM_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? MMCM_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int c_TMAX_B   = (LOCK_STABLE_CYCLES > c_REL_LAST + 1) ? LOCK_STABLE_CYCLES : c_REL_LAST + 1;
   localparam int c_TMAX     = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
   localparam int c_TW       = $clog2(c_TMAX + 1);

   logic [SYNC_STAGES-1:0] r_lk_sync;
   logic [SYNC_STAGES-1:0] r_frc_sync;
   logic [2:0]             r_state;
   logic [c_TW-1:0]        r_tmr;
   logic                   r_mmcm_rst;
   logic [N_CH-1:0]        r_ch_rst_n;
   logic                   r_all_ready;
   logic [CNT_W-1:0]       r_lock_loss_cnt;
   logic [CNT_W-1:0]       r_timeout_cnt;

   logic                   w_lk;
   logic                   w_frc;
   logic [2:0]             w_state_nxt;
   logic [c_TW-1:0]        w_tmr_nxt;
   logic                   w_ll_inc;
   logic                   w_to_inc;
   logic                   w_mmcm_rst_nxt;
   logic                   w_all_ready_nxt;
   logic [N_CH-1:0]        w_ch_rst_n_nxt;

   assign w_lk  = r_lk_sync[SYNC_STAGES-1];
   assign w_frc = r_frc_sync[SYNC_STAGES-1];

   // State register, single shared timer, synchronisers and registered outputs
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_lk_sync       <= '0;
         r_frc_sync      <= '0;
         r_state         <= S_MRST;
         r_tmr           <= '0;
         r_mmcm_rst      <= 1'b1;
         r_ch_rst_n      <= '0;
         r_all_ready     <= 1'b0;
         r_lock_loss_cnt <= '0;
         r_timeout_cnt   <= '0;
      end else begin
         r_lk_sync   <= {r_lk_sync[SYNC_STAGES-2:0], locked};
         r_frc_sync  <= {r_frc_sync[SYNC_STAGES-2:0], force_rst};
         r_state     <= w_state_nxt;
         r_tmr       <= w_tmr_nxt;
         r_mmcm_rst  <= w_mmcm_rst_nxt;
         r_ch_rst_n  <= w_ch_rst_n_nxt;
         r_all_ready <= w_all_ready_nxt;

         if (clr_cnt)
            r_lock_loss_cnt <= '0;
         else if (w_ll_inc && (r_lock_loss_cnt != '1))
            r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;

         if (clr_cnt)
            r_timeout_cnt <= '0;
         else if (w_to_inc && (r_timeout_cnt != '1))
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
   end

   // Priority: force request, then lock loss, then timeout
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_ll_inc    = 1'b0;
      w_to_inc    = 1'b0;
      if (w_frc) begin
         w_state_nxt = S_MRST;
         w_tmr_nxt   = '0;
      end else begin
         case (r_state)
            S_MRST: begin
               if (r_tmr == c_TW'(MMCM_RST_CYCLES - 1)) begin
                  w_state_nxt = S_WAIT;
                  w_tmr_nxt   = '0;
               end else begin
                  w_tmr_nxt = r_tmr + 1'b1;
               end
            end
            S_WAIT: begin
               if (w_lk) begin
                  w_state_nxt = S_STABLE;
                  w_tmr_nxt   = '0;
               end else if (r_tmr == c_TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  w_state_nxt = S_MRST;
                  w_tmr_nxt   = '0;
                  w_to_inc    = 1'b1;
               end else begin
                  w_tmr_nxt = r_tmr + 1'b1;
               end
            end
            S_STABLE: begin
               if (!w_lk) begin
                  w_state_nxt = S_WAIT;
                  w_tmr_nxt   = '0;
               end else if (r_tmr == c_TW'(LOCK_STABLE_CYCLES - 1)) begin
                  w_state_nxt = S_REL;
                  w_tmr_nxt   = '0;
               end else begin
                  w_tmr_nxt = r_tmr + 1'b1;
               end
            end
            S_REL: begin
               if (!w_lk) begin
                  w_state_nxt = S_WAIT;
                  w_tmr_nxt   = '0;
                  w_ll_inc    = 1'b1;
               end else if (r_tmr == c_TW'(c_REL_LAST)) begin
                  w_state_nxt = S_RUN;
                  w_tmr_nxt   = '0;
               end else begin
                  w_tmr_nxt = r_tmr + 1'b1;
               end
            end
            S_RUN: begin
               if (!w_lk) begin
                  w_state_nxt = S_WAIT;
                  w_tmr_nxt   = '0;
                  w_ll_inc    = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_MRST;
               w_tmr_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_mmcm_rst_nxt  = 1'b0;
      w_all_ready_nxt = 1'b0;
      if (w_state_nxt == S_MRST)
         w_mmcm_rst_nxt = 1'b1;
      if (w_state_nxt == S_RUN)
         w_all_ready_nxt = 1'b1;
   end

   // A channel latches released once its slot is reached; leaving REL/RUN drops all
   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_ch_rel
         assign w_ch_rst_n_nxt[g] = (w_state_nxt == S_RUN) ||
                                    ((w_state_nxt == S_REL) &&
                                     (r_ch_rst_n[g] || (w_tmr_nxt == c_TW'(g * STAGGER_CYCLES))));
      end
   endgenerate

   assign mmcm_rst      = r_mmcm_rst;
   assign ch_rst_n      = r_ch_rst_n;
   assign all_ready     = r_all_ready;
   assign state         = r_state;
   assign lock_loss_cnt = r_lock_loss_cnt;
   assign timeout_cnt   = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rst_sequencer
//  Description : Directed self-checking bench for clk_rst_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_sequencer;

   localparam int N_CH = 4;
   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RST_n;
   logic             locked;
   logic             force_rst;
   logic             clr_cnt;
   logic             mmcm_rst;
   logic [N_CH-1:0]  ch_rst_n;
   logic             all_ready;
   logic [2:0]       state;
   logic [CNT_W-1:0] lock_loss_cnt;
   logic [CNT_W-1:0] timeout_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Expected release pattern, one entry per cycle from REL entry to first RUN cycle
   logic [3:0] c_rel_ch    [14] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h3,
                                    4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
   logic [2:0] c_rel_state [14] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};

   always #5 CLK = ~CLK;

   clk_rst_sequencer #(
      .N_CH                (N_CH),
      .SYNC_STAGES         (2),
      .MMCM_RST_CYCLES     (3),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .STAGGER_CYCLES      (4),
      .CNT_W               (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RST_n         (RST_n),
      .locked        (locked),
      .force_rst     (force_rst),
      .clr_cnt       (clr_cnt),
      .mmcm_rst      (mmcm_rst),
      .ch_rst_n      (ch_rst_n),
      .all_ready     (all_ready),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Leaves RST_n released mid-cycle; the next edge is cycle 1 of MRST
   task automatic do_reset();
      RST_n = 1'b0; locked = 1'b0; force_rst = 1'b0; clr_cnt = 1'b0;
      tick(2);
      RST_n = 1'b1;
   endtask

   task automatic bring_up();
      do_reset();
      tick(3);
      locked = 1'b1;
      tick(24);
   endtask

   task automatic test_reset();
      RST_n = 1'b0; locked = 1'b0; force_rst = 1'b0; clr_cnt = 1'b0;
      tick(2);
      n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_checks++; if (mmcm_rst !== 1'b1) begin n_errors++; $display("FAIL reset_mmcm: got %b expected 1", mmcm_rst); end
      n_checks++; if (ch_rst_n !== 4'h0) begin n_errors++; $display("FAIL reset_ch: got %b expected 0000", ch_rst_n); end
      n_checks++; if (all_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", all_ready); end
      n_checks++; if (lock_loss_cnt !== 4'd0 || timeout_cnt !== 4'd0) begin n_errors++;
         $display("FAIL reset_cnt: got %0d/%0d expected 0/0", lock_loss_cnt, timeout_cnt); end
      RST_n = 1'b1;
      tick(2);
      n_checks++; if (mmcm_rst !== 1'b1 || state !== 3'd0) begin n_errors++;
         $display("FAIL mrst_hold: got mmcm=%b state=%0d expected 1/0", mmcm_rst, state); end
      tick(1);
      n_checks++; if (mmcm_rst !== 1'b0 || state !== 3'd1) begin n_errors++;
         $display("FAIL mrst_end: got mmcm=%b state=%0d expected 0/1", mmcm_rst, state); end
      locked = 1'b1;
      tick(3);
      n_checks++; if (state !== 3'd2) begin n_errors++; $display("FAIL stable_entry: got %0d expected 2", state); end
      tick(7);
      n_checks++; if (state !== 3'd2 || ch_rst_n !== 4'h0) begin n_errors++;
         $display("FAIL stable_last: got state=%0d ch=%b expected 2/0000", state, ch_rst_n); end
      for (int i = 0; i < 14; i++) begin
         tick(1);
         n_checks++; if (ch_rst_n !== c_rel_ch[i] || state !== c_rel_state[i] || all_ready !== (i == 13)) begin
            n_errors++;
            $display("FAIL release_step%0d: got ch=%b state=%0d ready=%b expected ch=%b state=%0d ready=%b",
                     i, ch_rst_n, state, all_ready, c_rel_ch[i], c_rel_state[i], (i == 13));
         end
      end
   endtask

   task automatic test_lock_drop();
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      n_checks++; if (ch_rst_n !== 4'hF) begin n_errors++; $display("FAIL drop_t1: got %b expected 1111", ch_rst_n); end
      tick(1);
      n_checks++; if (ch_rst_n !== 4'hF || all_ready !== 1'b1) begin n_errors++;
         $display("FAIL drop_t2: got ch=%b ready=%b expected 1111/1", ch_rst_n, all_ready); end
      tick(1);
      n_checks++; if (ch_rst_n !== 4'h0 || all_ready !== 1'b0 || state !== 3'd1) begin n_errors++;
         $display("FAIL drop_t3: got ch=%b ready=%b state=%0d expected 0000/0/1", ch_rst_n, all_ready, state); end
      n_checks++; if (lock_loss_cnt !== 4'd1) begin n_errors++; $display("FAIL drop_cnt: got %0d expected 1", lock_loss_cnt); end
      tick(1);
      n_checks++; if (state !== 3'd2) begin n_errors++; $display("FAIL drop_restable: got %0d expected 2", state); end
      tick(20);
      n_checks++; if (state !== 3'd3 || ch_rst_n !== 4'hF) begin n_errors++;
         $display("FAIL drop_rerel: got state=%0d ch=%b expected 3/1111", state, ch_rst_n); end
      tick(1);
      n_checks++; if (state !== 3'd4 || all_ready !== 1'b1) begin n_errors++;
         $display("FAIL drop_rerun: got state=%0d ready=%b expected 4/1", state, all_ready); end
   endtask

   task automatic test_timeout();
      logic [3:0] exp_to;
      locked = 1'b0;
      tick(3);
      n_checks++; if (state !== 3'd1 || lock_loss_cnt !== 4'd2) begin n_errors++;
         $display("FAIL to_wait: got state=%0d ll=%0d expected 1/2", state, lock_loss_cnt); end
      tick(31);
      n_checks++; if (state !== 3'd1 || timeout_cnt !== 4'd0) begin n_errors++;
         $display("FAIL to_last_wait: got state=%0d to=%0d expected 1/0", state, timeout_cnt); end
      tick(1);
      n_checks++; if (state !== 3'd0 || mmcm_rst !== 1'b1 || timeout_cnt !== 4'd1) begin n_errors++;
         $display("FAIL to_first: got state=%0d mmcm=%b to=%0d expected 0/1/1", state, mmcm_rst, timeout_cnt); end
      tick(2);
      n_checks++; if (mmcm_rst !== 1'b1) begin n_errors++; $display("FAIL to_pulse_end: got %b expected 1", mmcm_rst); end
      tick(1);
      n_checks++; if (mmcm_rst !== 1'b0 || state !== 3'd1) begin n_errors++;
         $display("FAIL to_pulse_off: got mmcm=%b state=%0d expected 0/1", mmcm_rst, state); end
      for (int i = 2; i <= 17; i++) begin
         if (i == 2) tick(32);
         else tick(35);
         exp_to = (i > 15) ? 4'd15 : 4'(i);
         n_checks++; if (mmcm_rst !== 1'b1 || timeout_cnt !== exp_to) begin n_errors++;
            $display("FAIL to_retry%0d: got mmcm=%b to=%0d expected 1/%0d", i, mmcm_rst, timeout_cnt, exp_to); end
      end
   endtask

   task automatic test_glitch();
      bit saw_stable;
      saw_stable = 1'b0;
      do_reset();
      tick(3);
      for (int c = 0; c < 60; c++) begin
         locked = ((c % 5) < 3);
         tick(1);
         if (state === 3'd2) saw_stable = 1'b1;
         n_checks++; if (ch_rst_n !== 4'h0 || state === 3'd3 || state === 3'd4) begin n_errors++;
            $display("FAIL glitch_c%0d: got ch=%b state=%0d expected 0000 and no REL/RUN", c, ch_rst_n, state); end
      end
      n_checks++; if (saw_stable !== 1'b1) begin n_errors++; $display("FAIL glitch_stable: got %b expected 1", saw_stable); end
      n_checks++; if (lock_loss_cnt !== 4'd0 || timeout_cnt !== 4'd0) begin n_errors++;
         $display("FAIL glitch_cnt: got %0d/%0d expected 0/0", lock_loss_cnt, timeout_cnt); end
   endtask

   task automatic test_force();
      do_reset();
      tick(3);
      locked = 1'b1;
      tick(15);
      n_checks++; if (ch_rst_n !== 4'h3 || state !== 3'd3) begin n_errors++;
         $display("FAIL force_pre: got ch=%b state=%0d expected 0011/3", ch_rst_n, state); end
      force_rst = 1'b1;
      locked    = 1'b0;
      tick(2);
      n_checks++; if (ch_rst_n !== 4'h3 || state !== 3'd3) begin n_errors++;
         $display("FAIL force_sync: got ch=%b state=%0d expected 0011/3", ch_rst_n, state); end
      tick(1);
      n_checks++; if (ch_rst_n !== 4'h0 || state !== 3'd0 || mmcm_rst !== 1'b1 || all_ready !== 1'b0) begin n_errors++;
         $display("FAIL force_hit: got ch=%b state=%0d mmcm=%b ready=%b expected 0000/0/1/0",
                  ch_rst_n, state, mmcm_rst, all_ready); end
      tick(7);
      force_rst = 1'b0;
      n_checks++; if (state !== 3'd0 || mmcm_rst !== 1'b1) begin n_errors++;
         $display("FAIL force_hold: got state=%0d mmcm=%b expected 0/1", state, mmcm_rst); end
      tick(4);
      n_checks++; if (state !== 3'd0 || mmcm_rst !== 1'b1) begin n_errors++;
         $display("FAIL force_tail: got state=%0d mmcm=%b expected 0/1", state, mmcm_rst); end
      tick(1);
      n_checks++; if (state !== 3'd1 || mmcm_rst !== 1'b0) begin n_errors++;
         $display("FAIL force_exit: got state=%0d mmcm=%b expected 1/0", state, mmcm_rst); end
      n_checks++; if (lock_loss_cnt !== 4'd0) begin n_errors++; $display("FAIL force_ll: got %0d expected 0", lock_loss_cnt); end
   endtask

   task automatic test_clr_and_async();
      bring_up();
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(2);
      n_checks++; if (lock_loss_cnt !== 4'd1) begin n_errors++; $display("FAIL clr_pre: got %0d expected 1", lock_loss_cnt); end
      tick(22);
      n_checks++; if (state !== 3'd4) begin n_errors++; $display("FAIL clr_run: got %0d expected 4", state); end
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(1);
      clr_cnt = 1'b1;
      tick(1);
      clr_cnt = 1'b0;
      n_checks++; if (lock_loss_cnt !== 4'd0 || state !== 3'd1 || ch_rst_n !== 4'h0) begin n_errors++;
         $display("FAIL clr_same: got ll=%0d state=%0d ch=%b expected 0/1/0000", lock_loss_cnt, state, ch_rst_n); end
      tick(13);
      n_checks++; if (ch_rst_n !== 4'h3 || state !== 3'd3) begin n_errors++;
         $display("FAIL async_pre: got ch=%b state=%0d expected 0011/3", ch_rst_n, state); end
      #3;
      RST_n = 1'b0;
      #1;
      n_checks++; if (state !== 3'd0 || mmcm_rst !== 1'b1 || ch_rst_n !== 4'h0 || all_ready !== 1'b0) begin n_errors++;
         $display("FAIL async_rst: got state=%0d mmcm=%b ch=%b ready=%b expected 0/1/0000/0",
                  state, mmcm_rst, ch_rst_n, all_ready); end
      RST_n = 1'b1;
   endtask

   initial begin
      RST_n = 1'b0; locked = 1'b0; force_rst = 1'b0; clr_cnt = 1'b0;
      test_reset();
      test_lock_drop();
      test_timeout();
      test_glitch();
      test_force();
      test_clr_and_async();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Supervises a clock-wizard (MMCM) instance from the buffered board clock, CLK.
- Pulses the MMCM reset, waits for a stable `locked`, then releases N_CH per-domain resets in staggered order.
- On lock loss it re-asserts all resets immediately; on lock timeout it retries the MMCM reset.
- Counts lock-loss and timeout events for debug/ILA; sits beside the clock wizard at the top level.

Parameters:
- N_CH, 4, number of channel resets (one per generated clock domain), >=1
- SYNC_STAGES, 2, flops in the `locked`/`force_rst` synchronisers, >=2
- MMCM_RST_CYCLES, 8, length of the mmcm_rst pulse in CLK cycles, >=1
- LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release, >=1
- LOCK_TIMEOUT_CYCLES, 65536, max cycles waiting for lock before an MMCM retry, >=1
- STAGGER_CYCLES, 16, cycles between successive channel releases, >=1
- CNT_W, 8, width of the event counters

Ports:
- CLK  input  1  board reference clock (post-BUFG)
- RST_n  input  1  asynchronous active-low reset
- locked  input  1  MMCM locked, asynchronous to CLK
- force_rst  input  1  manual re-sequence request (e.g. SW), asynchronous, level
- clr_cnt  input  1  synchronous clear of both event counters
- mmcm_rst  output  1  active-high reset to the clock wizard
- ch_rst_n  output  N_CH  active-low per-domain resets; bit 0 released first
- all_ready  output  1  high only in RUN
- state  output  3  encoded FSM state: 0=MRST, 1=WAIT, 2=STABLE, 3=REL, 4=RUN
- lock_loss_cnt  output  CNT_W  lock drops seen in REL/RUN, saturating
- timeout_cnt  output  CNT_W  lock-wait timeouts, saturating

Behaviour:
- One clock domain, CLK. RST_n asynchronously clears every flop, including the synchronisers.
- Reset values:
  - state=MRST, mmcm_rst=1, ch_rst_n=all 0, all_ready=0
  - both counters 0, internal timers 0
- `locked` and `force_rst` each pass through a SYNC_STAGES-deep synchroniser; lk and frc denote the synced values. All outputs are registered.
- MRST:
  - mmcm_rst=1 for exactly MMCM_RST_CYCLES cycles, counted from state entry.
  - Then go to WAIT; mmcm_rst=0 from the first WAIT cycle.
- WAIT:
  - If lk=1, go to STABLE.
  - Else, after LOCK_TIMEOUT_CYCLES cycles in WAIT, go to MRST and increment timeout_cnt.
- STABLE:
  - Counts consecutive lk=1 cycles.
  - If lk=0, return to WAIT with the wait timer restarted; no counter increment.
  - After LOCK_STABLE_CYCLES cycles, go to REL.
- REL:
  - Uses a release timer k, starting at 0 on entry.
  - ch_rst_n[i] goes to 1 in the cycle where k = i*STAGGER_CYCLES; bit 0 is released in the first REL cycle.
  - The cycle after ch_rst_n[N_CH-1] rises, go to RUN.
- RUN: all_ready=1, ch_rst_n all 1.
- Lock loss (lk=0 observed in REL or RUN at cycle t):
  - At t+1: ch_rst_n all 0, all_ready=0, state=WAIT.
  - lock_loss_cnt increments once per drop.
  - Worst-case latency from raw `locked` falling to reset asserted: SYNC_STAGES+1 cycles.
- force_rst:
  - frc=1 in any state sends the FSM to MRST next cycle, with ch_rst_n all 0 and all_ready=0.
  - The FSM stays in MRST (mmcm_rst held 1) while frc=1.
  - The MMCM_RST_CYCLES count starts after frc returns to 0.
  - Priority: frc over lock loss over timeout. If lk=0 and frc=1 in the same cycle, lock_loss_cnt is not incremented.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt=1 zeroes both counters next cycle, overriding a simultaneous increment (result 0).
- ch_rst_n never rises outside REL/RUN. Once in REL, release order is strictly ascending.
- An lk glitch shorter than one cycle after synchronisation is not filtered; STABLE provides the debounce before release.

Test Plan (N_CH=4, SYNC_STAGES=2, MMCM_RST_CYCLES=3, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=4, CNT_W=4):
- Reset then locked=1 at cycle 5:
  - mmcm_rst high for cycles 0-2 after RST_n release.
  - WAIT, then STABLE for 8 cycles.
  - ch_rst_n = 0001, 0011, 0111, 1111 at 4-cycle spacing.
  - all_ready=1 one cycle after 1111; state=4.
- In RUN, drop locked for 1 cycle: ch_rst_n=0000 and all_ready=0 exactly 3 cycles after the drop; lock_loss_cnt=1; full re-sequence follows.
- locked held 0: mmcm_rst re-pulses every 3+32 cycles; timeout_cnt reaches 15 and stays 15 (saturation).
- locked toggles with a 5-cycle period during STABLE: the FSM never reaches REL; ch_rst_n stays 0000; no counter changes.
- force_rst=1 for 10 cycles during REL (ch_rst_n=0011):
  - Next cycle after frc rises: 0000, state=0.
  - mmcm_rst stays high until 3 cycles after frc falls.
  - lock_loss_cnt is unchanged.
- Lock drop and clr_cnt in the same cycle: lock_loss_cnt=0 afterwards. Asserting RST_n low mid-REL clears all outputs asynchronously to their reset values.
